// File: rtl/weight_fetch_biu_if.sv
// Weight BIU bus bundle: arbiter request/response channels plus the MAC-array weight buffer write port.
// master = the BIU side, slave = arbiter/buffer side.
interface weight_fetch_biu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              weight_biu2arb_req;
    logic              weight_biu2arb_vld;
    logic [ADDR_W-1:0] weight_biu2arb_addr;
    logic              weight_biu2arb_rdy;
    logic [DATA_W-1:0] arb2weight_biu_data;
    logic              arb2weight_biu_vld;
    logic              arb2weight_biu_rdy;
    logic [ADDR_W-1:0] weight_waddr;
    logic [DATA_W-1:0] weight_wdata;
    logic              weight_wen;
    logic              weight_wrdy;

    modport master (
        output weight_biu2arb_req, weight_biu2arb_vld, weight_biu2arb_addr,
        input  weight_biu2arb_rdy,
        input  arb2weight_biu_data, arb2weight_biu_vld,
        output arb2weight_biu_rdy,
        output weight_waddr, weight_wdata, weight_wen,
        input  weight_wrdy
    );

    modport slave (
        input  weight_biu2arb_req, weight_biu2arb_vld, weight_biu2arb_addr,
        output weight_biu2arb_rdy,
        output arb2weight_biu_data, arb2weight_biu_vld,
        input  arb2weight_biu_rdy,
        input  weight_waddr, weight_wdata, weight_wen,
        output weight_wrdy
    );
endinterface

// File: rtl/weight_fetch_biu.sv
// Weight fetch BIU: reads one output channel's 3x3 then 1x1 kernel over the arbiter bus and
// streams the returned words into the weight buffer, with an outstanding-request window and abort/drain.
module weight_fetch_biu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int IN_CH   = 16,
    parameter int OCH_W   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              weight_start,
    input  logic              weight_abort,
    input  logic [OCH_W-1:0]  weight_och_cnt,
    input  logic [ADDR_W-1:0] weight3_base_addr,
    input  logic [ADDR_W-1:0] weight1_base_addr,
    output logic              weight_busy,
    output logic              weight_done,
    weight_fetch_biu_if.master bus
);
    localparam int N3    = 9 * IN_CH;
    localparam int N1    = IN_CH;
    localparam int B     = DATA_W / 8;
    localparam int CNT_W = $clog2(N3 + 1);

    typedef enum logic [2:0] {IDLE, REQ3, REQ1, WAIT, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] base1_q;
    logic [OCH_W-1:0]  och_q;
    logic [CNT_W-1:0]  req_cnt;
    logic [3:0]        outst, outst_nxt;
    logic              wr_ph;
    logic [3:0]        tap_cnt;
    logic [5:0]        ch_cnt;
    logic              done_q;

    logic arb_req, arb_vld, rsp_rdy, wr_state;
    logic req_hs, rsp_hs, wr_en, last_wr, start_ok;

    assign req_hs   = arb_vld & bus.weight_biu2arb_rdy;
    assign rsp_hs   = bus.arb2weight_biu_vld & rsp_rdy;
    assign wr_en    = rsp_hs & wr_state;
    assign last_wr  = wr_en & wr_ph & (ch_cnt == 6'(IN_CH - 1));
    assign start_ok = weight_start & ~weight_abort;

    // Stale responses (after reset or in drain) may arrive with outst==0; hold at zero.
    always_comb begin
        outst_nxt = outst;
        unique case ({req_hs, rsp_hs})
            2'b10:   outst_nxt = outst + 4'd1;
            2'b01:   outst_nxt = (outst == '0) ? '0 : outst - 4'd1;
            default: outst_nxt = outst;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start_ok) state_nxt = REQ3;
            REQ3:  if (weight_abort) state_nxt = DRAIN;
                   else if (req_hs && req_cnt == CNT_W'(N3 - 1)) state_nxt = REQ1;
            REQ1:  if (weight_abort) state_nxt = DRAIN;
                   else if (req_hs && req_cnt == CNT_W'(N1 - 1)) state_nxt = WAIT;
            WAIT:  if (weight_abort) state_nxt = DRAIN;
                   else if (last_wr) state_nxt = IDLE;
            DRAIN: if (outst_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        arb_req  = 1'b0;
        arb_vld  = 1'b0;
        rsp_rdy  = 1'b1;
        wr_state = 1'b0;
        unique case (state)
            REQ3, REQ1: begin
                arb_req  = 1'b1;
                arb_vld  = (outst < 4'(MAX_OUT));
                rsp_rdy  = bus.weight_wrdy;
                wr_state = 1'b1;
            end
            WAIT: begin
                arb_req  = 1'b1;
                rsp_rdy  = bus.weight_wrdy;
                wr_state = 1'b1;
            end
            DRAIN:   arb_req = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        bus.weight_biu2arb_req  = arb_req;
        bus.weight_biu2arb_vld  = arb_vld;
        bus.weight_biu2arb_addr = addr_q;
        bus.arb2weight_biu_rdy  = rsp_rdy;
        bus.weight_wen          = wr_en;
        bus.weight_wdata        = bus.arb2weight_biu_data;
        bus.weight_waddr                 = '0;
        bus.weight_waddr[ADDR_W-1]       = wr_ph;
        bus.weight_waddr[ADDR_W-2 -: 8]  = 8'(och_q);
        bus.weight_waddr[11:6]           = {2'b00, tap_cnt};
        bus.weight_waddr[5:0]            = ch_cnt;
    end

    assign weight_busy = (state != IDLE);
    assign weight_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            base1_q <= '0;
            och_q   <= '0;
            req_cnt <= '0;
            outst   <= '0;
            wr_ph   <= 1'b0;
            tap_cnt <= '0;
            ch_cnt  <= '0;
            done_q  <= 1'b0;
        end else begin
            outst  <= outst_nxt;
            done_q <= (state == WAIT) && !weight_abort && last_wr;

            unique case (state)
                IDLE: if (start_ok) begin
                    addr_q  <= weight3_base_addr + ADDR_W'(weight_och_cnt) * ADDR_W'(N3 * B);
                    base1_q <= weight1_base_addr;
                    och_q   <= weight_och_cnt;
                    req_cnt <= '0;
                    wr_ph   <= 1'b0;
                    tap_cnt <= '0;
                    ch_cnt  <= '0;
                end
                REQ3: if (req_hs) begin
                    if (req_cnt == CNT_W'(N3 - 1)) begin
                        addr_q  <= base1_q + ADDR_W'(och_q) * ADDR_W'(N1 * B);
                        req_cnt <= '0;
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(B);
                        req_cnt <= req_cnt + 1'b1;
                    end
                end
                REQ1: if (req_hs) begin
                    addr_q  <= addr_q + ADDR_W'(B);
                    req_cnt <= req_cnt + 1'b1;
                end
                default: ;
            endcase

            // tap/ch wrap counters stand in for r/IN_CH and r%IN_CH
            if (wr_en) begin
                if (ch_cnt == 6'(IN_CH - 1)) begin
                    ch_cnt <= '0;
                    if (!wr_ph) begin
                        if (tap_cnt == 4'd8) begin
                            tap_cnt <= '0;
                            wr_ph   <= 1'b1;
                        end else begin
                            tap_cnt <= tap_cnt + 4'd1;
                        end
                    end
                end else begin
                    ch_cnt <= ch_cnt + 6'd1;
                end
            end
        end
    end

    rsp_after_req_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_hs && outst == '0 && wr_state));

endmodule

// File: tb/tb_weight_fetch_biu.sv
// Randomized bench for weight_fetch_biu against a queue-based model of the fetch
// (expected request addresses, expected buffer writes) and a simple in-order arbiter responder.
module tb_weight_fetch_biu;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int IN_CH   = 16;
    localparam int OCH_W   = 8;
    localparam int MAX_OUT = 4;
    localparam int N3 = 9 * IN_CH;
    localparam int N1 = IN_CH;
    localparam int NW = N3 + N1;
    localparam int B  = DATA_W / 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        weight_start = 1'b0;
    logic        weight_abort = 1'b0;
    logic [7:0]  weight_och_cnt = '0;
    logic [31:0] weight3_base_addr = '0;
    logic [31:0] weight1_base_addr = '0;
    logic        weight_busy;
    logic        weight_done;

    weight_fetch_biu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    weight_fetch_biu #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IN_CH(IN_CH), .OCH_W(OCH_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .weight_start      (weight_start),
        .weight_abort      (weight_abort),
        .weight_och_cnt    (weight_och_cnt),
        .weight3_base_addr (weight3_base_addr),
        .weight1_base_addr (weight1_base_addr),
        .weight_busy       (weight_busy),
        .weight_done       (weight_done),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit rst_q = 1'b0, start_q = 1'b0, abort_q = 1'b0;
    bit full_mode = 1'b1, stall_win = 1'b0;
    int rdy_pct = 100, wrdy_pct = 100, rsp_pct = 100, lat_max = 2;
    int start_cyc = 0;

    bit          m_busy = 1'b0, m_drain = 1'b0, done_exp = 1'b0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] pend_d[$];
    int          pend_t[$];
    bit          rsp_hold = 1'b0;
    int          wr_cnt = 0;

    function automatic logic [31:0] rsp_of(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_start();
        logic [31:0] a3, a1, wa;
        exp_a.delete(); exp_wa.delete(); exp_wd.delete();
        a3 = weight3_base_addr + 32'(weight_och_cnt) * 32'(N3 * B);
        a1 = weight1_base_addr + 32'(weight_och_cnt) * 32'(N1 * B);
        for (int i = 0; i < N3; i++) exp_a.push_back(a3 + 32'(i * B));
        for (int i = 0; i < N1; i++) exp_a.push_back(a1 + 32'(i * B));
        for (int r = 0; r < NW; r++) begin
            wa = '0;
            wa[31]    = (r >= N3);
            wa[30:23] = weight_och_cnt;
            if (r < N3) wa[11:6] = 6'(r / IN_CH);
            wa[5:0]   = 6'(r % IN_CH);
            exp_wa.push_back(wa);
            exp_wd.push_back(rsp_of(exp_a[r]));
        end
        m_busy = 1'b1; m_drain = 1'b0; wr_cnt = 0; start_cyc = cyc;
    endtask

    task automatic step();
        bit req_hs, rsp_hs, writing;
        @(negedge clk);
        cyc++;
        rst_n = rst_q;
        weight_start = start_q; weight_abort = abort_q;
        start_q = 1'b0; abort_q = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_drain = 1'b0; done_exp = 1'b0;
            exp_a.delete(); exp_wa.delete(); exp_wd.delete();
        end
        bus.weight_biu2arb_rdy = full_mode ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
        bus.weight_wrdy        = full_mode ? 1'b1 : ($urandom_range(0, 99) < wrdy_pct);
        if (stall_win && (cyc - start_cyc) inside {[20:40]}) bus.weight_wrdy = 1'b0;
        if (!rst_n) rsp_hold = 1'b0;
        else if (!rsp_hold && pend_d.size() > 0 && pend_t[0] <= cyc &&
                 (full_mode || $urandom_range(0, 99) < rsp_pct)) rsp_hold = 1'b1;
        bus.arb2weight_biu_vld  = rsp_hold;
        bus.arb2weight_biu_data = rsp_hold ? pend_d[0] : $urandom();
        #1;
        writing = m_busy && !m_drain;
        check("busy", 32'(weight_busy), 32'(m_busy));
        check("done", 32'(weight_done), 32'(done_exp));
        check("arb_req", 32'(bus.weight_biu2arb_req), 32'(m_busy));
        check("arb_vld", 32'(bus.weight_biu2arb_vld),
              32'(writing && exp_a.size() > 0 && pend_d.size() < MAX_OUT));
        check("rsp_rdy", 32'(bus.arb2weight_biu_rdy), 32'(writing ? bus.weight_wrdy : 1'b1));
        if (!rst_n) begin
            check("rst_addr", bus.weight_biu2arb_addr, 32'h0);
            check("rst_waddr", bus.weight_waddr, 32'h0);
        end
        req_hs = bus.weight_biu2arb_vld && bus.weight_biu2arb_rdy;
        rsp_hs = bus.arb2weight_biu_vld && bus.arb2weight_biu_rdy;
        if (req_hs) begin
            if (exp_a.size() == 0) check("req_extra", 32'd1, 32'd0);
            else check("req_addr", bus.weight_biu2arb_addr, exp_a.pop_front());
            pend_d.push_back(rsp_of(bus.weight_biu2arb_addr));
            pend_t.push_back(cyc + (full_mode ? 2 : int'($urandom_range(1, lat_max))));
        end
        check("wen", 32'(bus.weight_wen), 32'(rsp_hs && writing));
        if (rsp_hs && writing) begin
            if (exp_wa.size() == 0) check("wr_extra", 32'd1, 32'd0);
            else begin
                check("waddr", bus.weight_waddr, exp_wa.pop_front());
                check("wdata", bus.weight_wdata, exp_wd.pop_front());
                wr_cnt++;
            end
        end
        if (rsp_hs) begin
            void'(pend_d.pop_front()); void'(pend_t.pop_front());
            rsp_hold = 1'b0;
        end
        done_exp = 1'b0;
        if (!rst_n) ;
        else if (writing && weight_abort) m_drain = 1'b1;
        else if (writing && rsp_hs && exp_wa.size() == 0) begin
            m_busy = 1'b0; done_exp = 1'b1;
        end else if (m_drain && pend_d.size() == 0) begin
            m_busy = 1'b0; m_drain = 1'b0;
        end else if (!m_busy && weight_start && !weight_abort) model_start();
    endtask

    task automatic fetch(input logic [7:0] och, input logic [31:0] b3, input logic [31:0] b1);
        weight_och_cnt = och; weight3_base_addr = b3; weight1_base_addr = b1;
        start_q = 1'b1;
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 4000) begin step(); n++; end
        if (m_busy) check("timeout_idle", 32'(m_busy), 32'd0);
        repeat (2) step();
    endtask

    task automatic random_mode();
        full_mode = 1'b0; stall_win = 1'b0;
        rdy_pct = 60 + int'($urandom_range(0, 40));
        wrdy_pct = 60 + int'($urandom_range(0, 40));
        rsp_pct = 60 + int'($urandom_range(0, 40));
        lat_max = 1 + int'($urandom_range(0, 5));
    endtask

    initial begin
        int n;
        bus.weight_biu2arb_rdy = 1'b0; bus.weight_wrdy = 1'b0;
        bus.arb2weight_biu_vld = 1'b0; bus.arb2weight_biu_data = '0;
        rst_q = 1'b0; repeat (3) step();
        rst_q = 1'b1; repeat (2) step();

        // full-speed reference fetch
        full_mode = 1'b1; stall_win = 1'b0;
        fetch(8'd2, 32'h0000_1000, 32'h0000_8000); wait_idle();

        // write-side backpressure window
        stall_win = 1'b1;
        fetch(8'd2, 32'h0000_1000, 32'h0000_8000); wait_idle();

        // start while busy must be ignored
        random_mode();
        fetch(8'($urandom()), $urandom(), $urandom());
        repeat (30) step();
        weight_och_cnt = 8'($urandom()); weight3_base_addr = $urandom(); weight1_base_addr = $urandom();
        start_q = 1'b1; step();
        wait_idle();

        // abort after 50 writes, then drain
        random_mode();
        fetch(8'($urandom()), $urandom(), $urandom());
        n = 0;
        while (wr_cnt < 50 && n < 4000) begin step(); n++; end
        if (wr_cnt < 50) check("timeout_writes", 32'(wr_cnt), 32'd50);
        abort_q = 1'b1; step();
        wait_idle();

        // start and abort together in IDLE
        start_q = 1'b1; abort_q = 1'b1; step();
        repeat (3) step();

        // async reset during the 1x1 request phase, stale responses afterwards
        random_mode();
        fetch(8'($urandom()), $urandom(), $urandom());
        n = 0;
        while (!(exp_a.size() < N1 && exp_a.size() > 0) && n < 4000) begin step(); n++; end
        rst_q = 1'b0; repeat (2) step();
        rst_q = 1'b1; step();
        n = 0;
        while (pend_d.size() > 0 && n < 200) begin step(); n++; end
        if (pend_d.size() > 0) check("timeout_stale", 32'(pend_d.size()), 32'd0);
        fetch(8'($urandom()), $urandom(), $urandom()); wait_idle();

        // address wrap at the top of the space
        random_mode();
        fetch(8'd0, 32'hFFFF_FFF0, $urandom()); wait_idle();

        for (int k = 0; k < 3; k++) begin
            random_mode();
            fetch(8'($urandom()), $urandom(), $urandom()); wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
